// File: rtl/reg_file.sv
// LC-3b general-purpose register file (R0..R7) with the N/Z/P condition-code latch.
// Two combinational read ports; one write port and a CC load, both taken from the datapath bus.
module reg_file #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [$clog2(NREGS)-1:0] SR1,
  input  logic [$clog2(NREGS)-1:0] SR2,
  input  logic [$clog2(NREGS)-1:0] DR,
  input  logic [WIDTH-1:0]         BUS,
  input  logic                     LD_REG,
  input  logic                     LD_CC,
  output logic [WIDTH-1:0]         SR1_OUT,
  output logic [WIDTH-1:0]         SR2_OUT,
  output logic                     N,
  output logic                     Z,
  output logic                     P
);

  // Handshake: none. LD_REG and LD_CC are single-cycle strobes, sampled at
  // each rising edge while RST_N is high; there is no ready/backpressure.

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [2:0]       cc_q;
  logic [2:0]       cc_d;
  logic             bus_neg;
  logic             bus_zero;

  assign bus_neg  = BUS[WIDTH-1];
  assign bus_zero = (BUS == '0);

  always_comb begin
    regs_d = regs_q;
    if (LD_REG) begin
      regs_d[DR] = BUS;
    end
  end

  // {N,Z,P} stays one-hot: zero wins over sign, which is clear for zero anyway.
  always_comb begin
    cc_d = cc_q;
    if (LD_CC) begin
      cc_d = {bus_neg, bus_zero, !bus_neg && !bus_zero};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      cc_q <= 3'b010;
    end else begin
      regs_q <= regs_d;
      cc_q   <= cc_d;
    end
  end

  // No write-through: BUS is derived from SR1_OUT, so a bypass would loop.
  assign SR1_OUT   = regs_q[SR1];
  assign SR2_OUT   = regs_q[SR2];
  assign {N, Z, P} = cc_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: behavioural model checked every falling edge,
// plus hand-computed literal expectations for each scenario.
module tb_reg_file;

  logic        CLK;
  logic        RST_N;
  logic [2:0]  SR1;
  logic [2:0]  SR2;
  logic [2:0]  DR;
  logic [15:0] BUS;
  logic        LD_REG;
  logic        LD_CC;
  logic [15:0] SR1_OUT;
  logic [15:0] SR2_OUT;
  logic        N;
  logic        Z;
  logic        P;

  int checks = 0;
  int errors = 0;
  logic clk_en = 1'b0;
  logic cmp_en = 1'b0;

  logic [15:0] m_r [8];
  logic [2:0]  m_cc;

  reg_file #(.WIDTH(16), .NREGS(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .SR1(SR1), .SR2(SR2), .DR(DR), .BUS(BUS),
    .LD_REG(LD_REG), .LD_CC(LD_CC), .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT),
    .N(N), .Z(Z), .P(P)
  );

  // Clock / reset block: clock can be held still to check reset without edges.
  initial CLK = 1'b0;
  always begin
    #5;
    if (clk_en) CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model: eight words plus a flag triple, updated by the architectural rules.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
      m_cc = 3'b010;
    end else begin
      if (LD_REG) m_r[DR] = BUS;
      if (LD_CC) begin
        if (BUS == 16'h0000)      m_cc = 3'b010;
        else if (BUS >= 16'h8000) m_cc = 3'b100;
        else                      m_cc = 3'b001;
      end
    end
  end

  // Scoreboard compare: inputs change only just after rising edges.
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model_sr1", SR1_OUT, m_r[SR1]);
      check("model_sr2", SR2_OUT, m_r[SR2]);
      check("model_nzp", {13'd0, N, Z, P}, {13'd0, m_cc});
    end
  end

  // Driver tasks.
  task automatic edge_wait();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [2:0] dr, input logic [15:0] d, input logic reg_en, input logic cc_en);
    DR = dr; BUS = d; LD_REG = reg_en; LD_CC = cc_en;
    edge_wait();
    LD_REG = 1'b0; LD_CC = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] r, input logic [15:0] exp);
    SR1 = r; SR2 = 3'd7 - r;
    #1;
    check({name, "_p1"}, SR1_OUT, exp);
    SR1 = 3'd7 - r; SR2 = r;
    #1;
    check({name, "_p2"}, SR2_OUT, exp);
  endtask

  task automatic cc_check(input string name, input logic [2:0] exp);
    check(name, {13'd0, N, Z, P}, {13'd0, exp});
  endtask

  initial begin
    RST_N = 1'b1; SR1 = 3'd0; SR2 = 3'd0; DR = 3'd0; BUS = 16'h0000;
    LD_REG = 1'b0; LD_CC = 1'b0;
    #1 RST_N = 1'b0;
    #1;
    // Reset with no clock edges: every select pair reads zero.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        SR1 = a[2:0]; SR2 = b[2:0];
        #1;
        check("rst_sr1", SR1_OUT, 16'h0000);
        check("rst_sr2", SR2_OUT, 16'h0000);
      end
    end
    cc_check("rst_nzp", 3'b010);
    cmp_en = 1'b1;
    clk_en = 1'b1;
    // Edges while held in reset must not write.
    DR = 3'd1; BUS = 16'hBEEF; LD_REG = 1'b1; LD_CC = 1'b1;
    edge_wait();
    edge_wait();
    LD_REG = 1'b0; LD_CC = 1'b0;
    RST_N = 1'b1;
    rd_check("rst_hold_r1", 3'd1, 16'h0000);
    cc_check("rst_hold_nzp", 3'b010);

    // Write then read back.
    wr(3'd3, 16'h0004, 1'b1, 1'b0);
    SR1 = 3'd3; SR2 = 3'd3;
    #1;
    check("wr_r3_sr1", SR1_OUT, 16'h0004);
    check("wr_r3_sr2", SR2_OUT, 16'h0004);
    for (int i = 0; i < 8; i++) begin
      if (i != 3) rd_check("wr_others_zero", i[2:0], 16'h0000);
    end

    // Shifter round-trip: bench plays the shifter, BUS = SR1_OUT << 1.
    SR1 = 3'd3;
    #1;
    wr(3'd5, {SR1_OUT[14:0], 1'b0}, 1'b1, 1'b1);
    rd_check("shift_r5", 3'd5, 16'h0008);
    cc_check("shift_nzp", 3'b001);

    // Condition-code polarity.
    wr(3'd0, 16'hFFFE, 1'b0, 1'b1);
    cc_check("cc_neg", 3'b100);
    wr(3'd0, 16'h0000, 1'b0, 1'b1);
    cc_check("cc_zero", 3'b010);
    wr(3'd0, 16'h7FFF, 1'b0, 1'b1);
    cc_check("cc_pos", 3'b001);
    wr(3'd0, 16'h8000, 1'b0, 1'b0);
    cc_check("cc_hold", 3'b001);
    wr(3'd0, 16'h8000, 1'b0, 1'b1);
    cc_check("cc_min_neg", 3'b100);
    rd_check("cc_only_no_write", 3'd0, 16'h0000);
    wr(3'd6, 16'h0001, 1'b1, 1'b1);
    rd_check("both_r6", 3'd6, 16'h0001);
    cc_check("both_nzp", 3'b001);

    // Same-register read/write: old value until the edge.
    wr(3'd2, 16'h1234, 1'b1, 1'b0);
    SR1 = 3'd2; SR2 = 3'd2;
    DR = 3'd2; BUS = 16'hABCD; LD_REG = 1'b1;
    #1;
    check("same_before", SR1_OUT, 16'h1234);
    edge_wait();
    LD_REG = 1'b0;
    check("same_after_p1", SR1_OUT, 16'hABCD);
    check("same_after_p2", SR2_OUT, 16'hABCD);

    // Reset mid-operation with a pending write.
    for (int i = 0; i < 8; i++) wr(i[2:0], 16'hFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) rd_check("fill_ffff", i[2:0], 16'hFFFF);
    wr(3'd4, 16'hFFFF, 1'b0, 1'b1);
    cc_check("fill_nzp", 3'b100);
    DR = 3'd7; BUS = 16'h5555; LD_REG = 1'b1;
    @(negedge CLK);
    #1 RST_N = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) rd_check("mid_rst_zero", i[2:0], 16'h0000);
    cc_check("mid_rst_nzp", 3'b010);
    edge_wait();
    rd_check("mid_rst_r7_held", 3'd7, 16'h0000);
    RST_N = 1'b1;
    edge_wait();
    LD_REG = 1'b0;
    rd_check("post_rst_r7", 3'd7, 16'h5555);
    rd_check("post_rst_r6", 3'd6, 16'h0000);
    cc_check("post_rst_nzp", 3'b010);

    edge_wait();
    edge_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
